// File: rtl/banco_resp_if.sv
// banco_resp_if: ATM<->bank request/response link (4-phase REQ/ACK)
interface banco_resp_if;
    logic       req;
    logic [3:0] pin_in;
    logic [3:0] val_in;
    logic       par_in;
    logic       ack;
    logic [2:0] status;
    logic [3:0] saldo;
    logic       par;
    logic       bloq;
    modport master (output req, pin_in, val_in, par_in, input ack, status, saldo, par, bloq);
    modport slave (input req, pin_in, val_in, par_in, output ack, status, saldo, par, bloq);
endinterface

// File: rtl/banco_resp.sv
// banco_resp: bank-side responder; authorises PIN + withdrawal requests, owns balance and lockout
module banco_resp #(
    parameter logic [3:0] PIN_OK    = 4'b0101,
    parameter logic [3:0] SALDO_INI = 4'b1111,
    parameter int         MAX_TENT  = 3,
    parameter int         LAT       = 2
) (
    input logic          clk,
    input logic          rst,
    banco_resp_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PROC, RESP} state_t;
    localparam logic [2:0] ST_OK = 3'b000, ST_PIN_ERR = 3'b001, ST_SEM_SALDO = 3'b010,
                           ST_BLOQ = 3'b011, ST_ERR_PAR = 3'b100;
    localparam logic [3:0] CNT_INI = 4'(LAT - 1);
    localparam logic [2:0] TENT = 3'(MAX_TENT);
    state_t     state;
    logic [3:0] cnt, pin_q, val_q;
    logic       par_q;
    logic [2:0] tries, try_inc;
    assign try_inc = (tries < TENT) ? tries + 3'd1 : tries;
    assign bus.par = ^{bus.status, bus.saldo};
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            pin_q      <= 4'd0;
            val_q      <= 4'd0;
            par_q      <= 1'b0;
            tries      <= 3'd0;
            bus.ack    <= 1'b0;
            bus.status <= ST_OK;
            bus.saldo  <= SALDO_INI;
            bus.bloq   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req) begin
                    pin_q <= bus.pin_in;
                    val_q <= bus.val_in;
                    par_q <= bus.par_in;
                    cnt   <= CNT_INI;
                    state <= PROC;
                end
                PROC: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    bus.ack <= 1'b1;
                    state   <= RESP;
                    if (^{pin_q, val_q, par_q}) begin
                        bus.status <= ST_ERR_PAR;
                    end else if (bus.bloq) begin
                        bus.status <= ST_BLOQ;
                    end else if (pin_q != PIN_OK) begin
                        tries <= try_inc;
                        if (try_inc == TENT) begin
                            bus.bloq   <= 1'b1;
                            bus.status <= ST_BLOQ;
                        end else begin
                            bus.status <= ST_PIN_ERR;
                        end
                    end else begin
                        tries <= 3'd0;
                        // a zero amount falls through as a debit of nothing
                        if (val_q > bus.saldo) begin
                            bus.status <= ST_SEM_SALDO;
                        end else begin
                            bus.saldo  <= bus.saldo - val_q;
                            bus.status <= ST_OK;
                        end
                    end
                end
                RESP: if (!bus.req) begin
                    bus.ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_banco_resp.sv
// tb_banco_resp: directed transactions checked against a cycle-scheduled transaction model
module tb_banco_resp;
    localparam logic [3:0] PIN_OK    = 4'b0101;
    localparam logic [3:0] SALDO_INI = 4'b1111;
    localparam int         MAX_TENT  = 3;
    localparam int         LAT       = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    banco_resp_if bus ();

    banco_resp #(.PIN_OK(PIN_OK), .SALDO_INI(SALDO_INI), .MAX_TENT(MAX_TENT), .LAT(LAT))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: result is decided at capture and becomes visible LAT edges later
    int         cyc = 0, due = 0, m_tries = 0, p_tries = 0;
    bit         started = 0, pend = 0, m_ack = 0, m_bloq = 0, p_bloq = 0;
    logic [2:0] m_st = 3'd0, p_st = 3'd0;
    logic [3:0] m_saldo = SALDO_INI, p_saldo = SALDO_INI;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            pend = 0; m_ack = 0; m_st = 3'd0; m_saldo = SALDO_INI; m_bloq = 0; m_tries = 0;
        end else if (m_ack) begin
            if (!bus.req) m_ack = 0;
        end else if (pend) begin
            if (cyc == due) begin
                m_st = p_st; m_saldo = p_saldo; m_bloq = p_bloq; m_tries = p_tries;
                m_ack = 1; pend = 0;
            end
        end else if (bus.req) begin
            p_st = m_st; p_saldo = m_saldo; p_bloq = m_bloq; p_tries = m_tries;
            if (^{bus.pin_in, bus.val_in, bus.par_in}) p_st = 3'd4;
            else if (m_bloq) p_st = 3'd3;
            else if (bus.pin_in != PIN_OK) begin
                p_tries = (m_tries < MAX_TENT) ? m_tries + 1 : m_tries;
                if (p_tries == MAX_TENT) begin p_bloq = 1; p_st = 3'd3; end
                else p_st = 3'd1;
            end else begin
                p_tries = 0;
                if (bus.val_in > m_saldo) p_st = 3'd2;
                else begin p_saldo = m_saldo - bus.val_in; p_st = 3'd0; end
            end
            due = cyc + LAT;
            pend = 1;
        end
    end

    always @(negedge clk) if (started) begin
        chk("ack", 8'(bus.ack), 8'(m_ack));
        chk("status", 8'(bus.status), 8'(m_st));
        chk("saldo", 8'(bus.saldo), 8'(m_saldo));
        chk("bloq", 8'(bus.bloq), 8'(m_bloq));
        chk("par", 8'(bus.par), 8'(^{m_st, m_saldo}));
    end

    task automatic txn(input logic [3:0] p, input logic [3:0] v, input logic pi);
        int n;
        @(negedge clk);
        bus.pin_in = p; bus.val_in = v; bus.par_in = pi; bus.req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ack && n < 20);
        chk("latency", 8'(n), 8'(LAT + 1));
        bus.req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.ack && n < 20);
        chk("release", 8'(n), 8'd1);
    endtask

    initial begin
        int w;
        bus.req = 1'b0; bus.pin_in = 4'd0; bus.val_in = 4'd0; bus.par_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ack", 8'(bus.ack), 8'd0);
        chk("rst_status", 8'(bus.status), 8'd0);
        chk("rst_saldo", 8'(bus.saldo), 8'hF);
        chk("rst_bloq", 8'(bus.bloq), 8'd0);
        chk("rst_par", 8'(bus.par), 8'd0);
        txn(4'b0101, 4'b0101, 1'b0);
        chk("wd_status", 8'(bus.status), 8'd0);
        chk("wd_saldo", 8'(bus.saldo), 8'hA);
        chk("wd_par", 8'(bus.par), 8'd0);
        txn(4'b0101, 4'b1011, 1'b1);
        chk("nofunds_status", 8'(bus.status), 8'd2);
        chk("nofunds_saldo", 8'(bus.saldo), 8'hA);
        txn(4'b0101, 4'b0000, 1'b0);
        chk("query_status", 8'(bus.status), 8'd0);
        chk("query_saldo", 8'(bus.saldo), 8'hA);
        txn(4'b0101, 4'b0001, 1'b0);
        chk("parerr_status", 8'(bus.status), 8'd4);
        txn(4'b0000, 4'b0000, 1'b0);
        chk("bad1_status", 8'(bus.status), 8'd1);
        txn(4'b0101, 4'b0001, 1'b0);
        chk("parerr2_status", 8'(bus.status), 8'd4);
        txn(4'b0000, 4'b0000, 1'b0);
        chk("bad2_status", 8'(bus.status), 8'd1);
        chk("bad2_bloq", 8'(bus.bloq), 8'd0);
        txn(4'b0000, 4'b0000, 1'b0);
        chk("bad3_status", 8'(bus.status), 8'd3);
        chk("bad3_bloq", 8'(bus.bloq), 8'd1);
        txn(4'b0101, 4'b0001, 1'b1);
        chk("blocked_status", 8'(bus.status), 8'd3);
        chk("blocked_saldo", 8'(bus.saldo), 8'hA);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("unbloq", 8'(bus.bloq), 8'd0);
        chk("unbloq_saldo", 8'(bus.saldo), 8'hF);
        // REQ held for one edge only: ACK must still come and last one cycle
        @(negedge clk);
        bus.pin_in = 4'b0101; bus.val_in = 4'b0011; bus.par_in = 1'b0; bus.req = 1'b1;
        @(negedge clk); bus.req = 1'b0;
        w = 0;
        repeat (6) begin @(negedge clk); w += int'(bus.ack); end
        chk("pulse_width", 8'(w), 8'd1);
        chk("pulse_saldo", 8'(bus.saldo), 8'hC);
        txn(4'b0000, 4'b0000, 1'b0);
        txn(4'b0101, 4'b0000, 1'b0);
        txn(4'b0000, 4'b0000, 1'b0);
        txn(4'b0000, 4'b0000, 1'b0);
        chk("cleared_tries_status", 8'(bus.status), 8'd1);
        chk("cleared_tries_bloq", 8'(bus.bloq), 8'd0);
        // reset while processing aborts the debit
        @(negedge clk);
        bus.pin_in = 4'b0101; bus.val_in = 4'b0001; bus.par_in = 1'b1; bus.req = 1'b1;
        @(negedge clk); bus.req = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_saldo", 8'(bus.saldo), 8'hF);
        chk("abort_ack", 8'(bus.ack), 8'd0);
        txn(4'b0101, 4'b1111, 1'b0);
        chk("empty_saldo", 8'(bus.saldo), 8'h0);
        chk("empty_status", 8'(bus.status), 8'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/banco_resp.md
# banco_resp

Bank-side responder for the multibanco (MB) machine: accepts a PIN + withdrawal request from the ATM over a 4-phase REQ/ACK handshake and authorises or rejects it. It also keeps the account balance and the wrong-PIN counter, and returns a status code, the new balance and a parity bit. It sits opposite MB on the ATM↔bank link and is the authority for SALDO.

## Interface
- PIN_OK, 4'b0101, correct PIN for the single account held
- SALDO_INI, 4'b1111, balance loaded on reset
- MAX_TENT, 3, consecutive wrong PINs that block the card (1..7)
- LAT, 2, processing cycles between capture and response (1..15)

- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  1  request from ATM; data inputs stable while high
- PIN_IN  in  4  PIN typed by user
- VAL_IN  in  4  amount to withdraw; 0 = balance query
- PAR_IN  in  1  even parity: XOR of PIN_IN, VAL_IN, PAR_IN must be 0
- ACK  out  1  response valid; held until REQ low
- STATUS  out  3  000 OK, 001 PIN_ERR, 010 SEM_SALDO, 011 BLOQ, 100 ERR_PAR
- SALDO  out  4  current balance (registered)
- PAR  out  1  even parity over STATUS and SALDO: XOR of all 8 bits = 0
- BLOQ  out  1  card blocked; sticky until RST

## Operation
- States: IDLE, PROC, RESP.
- IDLE: on an edge with REQ=1, capture PIN_IN/VAL_IN/PAR_IN, load the delay counter with LAT-1, go to PROC.
- PROC: decrement the counter. The edge where it reaches 0 evaluates the captured request in strict priority order, registers the results, sets ACK=1 and goes to RESP.
  1. Parity fail → ERR_PAR. Balance and try counter unchanged.
  2. BLOQ=1 → BLOQ. Nothing changes.
  3. PIN ≠ PIN_OK → try counter +1. If the result equals MAX_TENT, set BLOQ=1 and report BLOQ; else report PIN_ERR.
  4. PIN ok → try counter cleared, then:
     - VAL=0 → OK, no debit.
     - VAL > SALDO → SEM_SALDO, no debit.
     - otherwise → SALDO ← SALDO − VAL, OK.
- Arithmetic: 4-bit unsigned. Underflow is impossible because of the compare; VAL=SALDO gives SALDO=0 and OK.
- RESP: hold ACK/STATUS/SALDO. On an edge with REQ=0, clear ACK and go to IDLE. STATUS and SALDO keep their last values.
- Try counter: 3 bits, saturates at MAX_TENT, cleared only by a correct PIN or RST.
- PAR is recomputed combinationally from the registered STATUS/SALDO, so it is always consistent, including during reset.

## Timing
- Reset values: ACK=0, STATUS=000, SALDO=SALDO_INI, BLOQ=0, try=0, state IDLE, PAR=^SALDO_INI.
- RST has priority over everything. Asserting it mid-transaction aborts: no debit is applied and ACK drops on the next edge.
- Latency: REQ sampled high at edge k gives ACK=1 and new STATUS/SALDO after edge k+LAT.
- REQ only matters in IDLE (start) and RESP (release). REQ dropping during PROC still completes the transaction; ACK then lasts exactly 1 cycle.
- ACK low → IDLE on the same edge. If REQ is high again at the next edge, a new capture happens, so the minimum transaction period is LAT+2 cycles.
- Input changes while not in IDLE are ignored; only the captured values are used.

## Test plan
- Reset: RST high 2 cycles → ACK=0, STATUS=000, SALDO=1111, BLOQ=0, PAR=0.
- Good withdrawal: PIN=0101, VAL=0101, PAR_IN=0; REQ at edge k → ACK high after edge k+2, STATUS=000, SALDO=1010, PAR=0. Drop REQ → ACK low next edge.
- Insufficient funds: SALDO=1010, VAL=1011, good PIN/parity → STATUS=010, SALDO stays 1010. Then VAL=0000 → STATUS=000, SALDO=1010.
- Lockout: three requests with PIN=0000 → STATUS 001, 001, 011 and BLOQ=1. A fourth request with PIN=0101 → STATUS=011, SALDO unchanged. RST clears BLOQ.
- Parity error: PIN=0101, VAL=0001, PAR_IN=0 → STATUS=100, try counter and SALDO unchanged. A following bad-PIN pair still takes 3 wrong PINs to reach lockout.
- Corner cases:
  - REQ dropped 1 cycle after capture → ACK is a 1-cycle pulse and the debit is applied.
  - RST during PROC → no debit and SALDO=SALDO_INI.
